rr_arbiter8: RTL and testbench
==============================

Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one 32-bit output channel among 8 latency-insensitive (val/rdy) requesters.
- Drives the 3-bit select of the downstream 8:1 word selection.
- Registers the winning word in a one-entry output buffer, so throughput is one word per cycle under back-to-back traffic.
- Sits between producer lanes (e.g. FFT/FIR result lanes) and a single consumer such as a SPI/TX stream.

Parameters:
- NBITS, 32, width of each message word.
- NREQ, 8, number of requesters. Fixed at 8; the select is 3 bits. Other values are unsupported.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- recv_msg  input  NREQ*NBITS  packed request words; requester i occupies bits [i*NBITS +: NBITS].
- recv_val  input  NREQ  per-requester valid.
- recv_rdy  output  NREQ  per-requester ready; one-hot or zero.
- send_msg  output  NBITS  registered output word.
- send_val  output  1  output buffer holds a word.
- send_rdy  input  1  consumer ready.
- grant_id  output  3  index of the requester whose word is in send_msg.

Behaviour:
- Reset (synchronous, active-high, sampled at clk rise): send_val=0, send_msg=0, grant_id=0, priority pointer ptr=0, lock state UNLOCKED.
  - During reset, recv_rdy=0 for all requesters.
  - Reset mid-transfer discards the buffered word. No transfer completes in the reset cycle.
- Load enable: load = !send_val || send_rdy. This is combinational, so send_rdy can reach recv_rdy in the same cycle; bubble-free.
- Winner selection: w = first i in ptr, ptr+1, ..., ptr+7 (mod 8) with recv_val[i]=1.
  - recv_rdy[w] = load && any(recv_val); all other recv_rdy bits = 0.
  - recv_rdy is never asserted for a lane with recv_val=0.
- Input transfer: a transfer on lane w occurs when recv_val[w] && recv_rdy[w]. Next cycle:
  - send_msg = recv_msg[w]
  - grant_id = w
  - send_val = 1
  - ptr = (w+1) mod 8 (wrap 7 -> 0)
- Output transfer: send_val && send_rdy.
  - If a new input transfer happens in the same cycle, send_val stays 1 with the new word.
  - Otherwise send_val goes to 0. send_msg and grant_id hold their last values.
- Backpressure: when send_val=1 and send_rdy=0, every recv_rdy=0. send_msg, grant_id and ptr hold.
- Latency: 1 cycle from accepted input to send_val.
- Fairness: with all 8 lanes continuously valid and send_rdy=1, grants are issued in order 0,1,...,7,0,... with no lane starved more than 7 grants.
- Lane stability: a requester may drop recv_val without a transfer. The arbiter re-evaluates the winner every cycle, and ptr moves only on a transfer.

Optional Feature:
- Macro: RR_ARBITER8_LOCK_EN.
- When defined:
  - Adds input port recv_last [NREQ-1:0], which marks the final word of a packet.
  - Adds a state machine with states UNLOCKED and LOCKED(owner).
  - UNLOCKED -> LOCKED(w) on a transfer from w with recv_last[w]=0.
  - While LOCKED, only owner may win; other lanes see recv_rdy=0 even if the owner is idle.
  - LOCKED -> UNLOCKED on an owner transfer with recv_last=1. ptr advances only on that transfer.
  - A single-word packet (recv_last=1 on first word) never enters LOCKED.
- When undefined: no recv_last port; every word is independently arbitrated as above.

Decomposition:
- Shared package rr_arb_pkg holds:
  - localparam NREQ=8 and SEL_W=3
  - typedef logic [SEL_W-1:0] sel_t
  - typedef enum {UNLOCKED, LOCKED} arb_state_e
- One sub-module is natural: rr_pick8.
  - Purely combinational rotate/priority-encode/rotate-back.
  - Inputs: req[7:0], ptr[2:0]. Outputs: any, idx[2:0].
  - Reused by other shared-resource controllers.

Test Plan:
1. Reset: hold reset=1 for 2 cycles with all recv_val=1 -> recv_rdy=0, send_val=0, grant_id=0. First post-reset grant goes to lane 0.
2. All 8 lanes valid with msg=0x1000_000i, send_rdy=1 for 16 cycles -> send_msg sequence 0x10000000..0x10000007 repeated twice, one word per cycle, grant_id matching; ptr wraps from 7 to 0.
3. Only lanes 2 and 5 valid, ptr=0 -> grants 2,5,2,5. A lane-0 request arriving after the lane-5 grant wins next, because ptr=6 wraps to 0 before 2.
4. Backpressure: send_rdy=0 for 4 cycles with send_val=1, then 1 -> recv_rdy all 0 and send_msg stable during stall. The next word is accepted in the same cycle send_rdy rises, so send_val never drops.
5. Drop request: lane 3 asserts recv_val while the buffer is stalled, then deasserts before send_rdy -> no transfer from lane 3; ptr unchanged.
6. With RR_ARBITER8_LOCK_EN: lane 1 sends a 3-word packet (last on word 3) while lane 4 is valid throughout -> lane 4 receives no recv_rdy until after lane 1's last word. Lane 4 is granted on the next cycle.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin arbiters.
// The packet-lock state type is used only by builds that define RR_ARBITER8_LOCK_EN.
package rr_arb_pkg;

  localparam int unsigned NREQ  = 8;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] sel_onehot(input sel_t s);
    return NREQ'(1) << s;
  endfunction

endpackage

// File: rtl/rr_arbiter8_if.sv
// Requester and consumer channel of rr_arbiter8.
// recv_last is present only when RR_ARBITER8_LOCK_EN is defined.
interface rr_arbiter8_if #(
  parameter int unsigned NBITS = 32
) ();
  import rr_arb_pkg::*;

  logic [NREQ*NBITS-1:0] recv_msg;
  logic [NREQ-1:0]       recv_val;
  logic [NREQ-1:0]       recv_rdy;
`ifdef RR_ARBITER8_LOCK_EN
  logic [NREQ-1:0]       recv_last;
`endif
  logic [NBITS-1:0]      send_msg;
  logic                  send_val;
  logic                  send_rdy;
  sel_t                  grant_id;

  // master: the arbiter; slave: producers and consumer around it
`ifdef RR_ARBITER8_LOCK_EN
  modport master (
    input  recv_msg, recv_val, recv_last, send_rdy,
    output recv_rdy, send_msg, send_val, grant_id
  );
  modport slave (
    output recv_msg, recv_val, recv_last, send_rdy,
    input  recv_rdy, send_msg, send_val, grant_id
  );
`else
  modport master (
    input  recv_msg, recv_val, send_rdy,
    output recv_rdy, send_msg, send_val, grant_id
  );
  modport slave (
    output recv_msg, recv_val, send_rdy,
    input  recv_rdy, send_msg, send_val, grant_id
  );
`endif

endinterface

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set bit of req at or after ptr, wrapping mod 8.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  sel_t            ptr,
  output logic            any,
  output sel_t            idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic              found;

  // Rotate so ptr sits at bit 0, priority-encode, then rotate the index back.
  always_comb begin
    dbl   = {req, req} >> ptr;
    rot   = dbl[NREQ-1:0];
    any   = |req;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        idx   = ptr + sel_t'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter with a one-entry registered output buffer.
// Define RR_ARBITER8_LOCK_EN to hold the grant on one lane until recv_last.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned NBITS = 32
) (
  input  logic          clk,
  input  logic          reset,
  rr_arbiter8_if.master bus
);

  logic [NREQ-1:0]  req_c;
  logic             load_c;
  logic             any_c;
  logic             xfer_c;
  sel_t             idx_c;
  sel_t             ptr;
  logic [NBITS-1:0] win_msg_c;

`ifdef RR_ARBITER8_LOCK_EN
  arb_state_e state;
  sel_t       owner;

  // While locked, only the owning lane is eligible.
  always_comb begin
    req_c = bus.recv_val;
    if (state == LOCKED) begin
      req_c = bus.recv_val & sel_onehot(owner);
    end
  end
`else
  always_comb begin
    req_c = bus.recv_val;
  end
`endif

  rr_pick8 u_pick (
    .req (req_c),
    .ptr (ptr),
    .any (any_c),
    .idx (idx_c)
  );

  // Buffer can take a word when empty or draining this cycle.
  assign load_c = !bus.send_val || bus.send_rdy;
  assign xfer_c = !reset && load_c && any_c;

  always_comb begin
    bus.recv_rdy = '0;
    if (xfer_c) begin
      bus.recv_rdy = sel_onehot(idx_c);
    end
  end

  always_comb begin
    win_msg_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (idx_c == sel_t'(i)) begin
        win_msg_c = bus.recv_msg[i*NBITS +: NBITS];
      end
    end
  end

  // Output buffer, priority pointer and optional packet lock.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.send_val <= 1'b0;
      bus.send_msg <= '0;
      bus.grant_id <= '0;
      ptr          <= '0;
`ifdef RR_ARBITER8_LOCK_EN
      state        <= UNLOCKED;
      owner        <= '0;
`endif
    end else begin
      if (xfer_c) begin
        bus.send_val <= 1'b1;
        bus.send_msg <= win_msg_c;
        bus.grant_id <= idx_c;
`ifdef RR_ARBITER8_LOCK_EN
        // Pointer advances only when a packet ends, so a packet is one grant.
        if (!bus.recv_last[idx_c]) begin
          state <= LOCKED;
          owner <= idx_c;
        end else begin
          state <= UNLOCKED;
          ptr   <= idx_c + sel_t'(1);
        end
`else
        ptr          <= idx_c + sel_t'(1);
`endif
      end else if (bus.send_rdy) begin
        bus.send_val <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed self-checking bench for rr_arbiter8; lock sequence runs when RR_ARBITER8_LOCK_EN is defined.
module tb_rr_arbiter8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  rr_arbiter8_if #(.NBITS(32)) bus ();

  rr_arbiter8 #(.NBITS(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] val;
    logic       srdy;
    logic [7:0] erdy;
    logic       esv;
    logic [2:0] egid;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Drive at posedge+1, check recv_rdy mid-cycle, check registered outputs at next posedge+1.
  task automatic step(input logic [7:0] val, input logic srdy, input logic [7:0] erdy,
                      input logic esv, input logic [2:0] egid, input string nm);
    logic [31:0] emsg;
    bus.recv_val = val;
    bus.send_rdy = srdy;
    #4;
    chk({nm, ".recv_rdy"}, 32'(bus.recv_rdy), 32'(erdy));
    @(posedge clk);
    #1;
    emsg = 32'h1000_0000 + 32'(egid);
    chk({nm, ".send_val"}, 32'(bus.send_val), 32'(esv));
    chk({nm, ".grant_id"}, 32'(bus.grant_id), 32'(egid));
    chk({nm, ".send_msg"}, bus.send_msg, emsg);
  endtask

  function automatic vec_t mk(input logic [7:0] val, input logic srdy, input logic [7:0] erdy,
                              input logic esv, input logic [2:0] egid);
    vec_t v;
    v.val = val; v.srdy = srdy; v.erdy = erdy; v.esv = esv; v.egid = egid;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 8; i++) bus.recv_msg[i*32 +: 32] = 32'h1000_0000 + 32'(i);
`ifdef RR_ARBITER8_LOCK_EN
    bus.recv_last = 8'hff;
`endif

    // Reset with every lane requesting
    reset        = 1'b1;
    bus.recv_val = 8'hff;
    bus.send_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("rst1.recv_rdy", 32'(bus.recv_rdy), 32'h0);
    @(posedge clk);
    #1;
    chk("rst2.recv_rdy", 32'(bus.recv_rdy), 32'h0);
    chk("rst.send_val", 32'(bus.send_val), 32'h0);
    chk("rst.grant_id", 32'(bus.grant_id), 32'h0);
    chk("rst.send_msg", bus.send_msg, 32'h0);
    reset = 1'b0;

    // All lanes valid: 0..7 twice
    for (int k = 0; k < 16; k++) vq.push_back(mk(8'hff, 1'b1, 8'(1 << (k % 8)), 1'b1, 3'(k % 8)));
    // Lanes 2 and 5, then lane 0 wraps ahead of 2, then drain
    vq.push_back(mk(8'h24, 1'b1, 8'h04, 1'b1, 3'd2));
    vq.push_back(mk(8'h24, 1'b1, 8'h20, 1'b1, 3'd5));
    vq.push_back(mk(8'h24, 1'b1, 8'h04, 1'b1, 3'd2));
    vq.push_back(mk(8'h24, 1'b1, 8'h20, 1'b1, 3'd5));
    vq.push_back(mk(8'h25, 1'b1, 8'h01, 1'b1, 3'd0));
    vq.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0));
    // Backpressure: fill with lane 1, stall 4 cycles, accept lane 2 on release
    vq.push_back(mk(8'h02, 1'b0, 8'h02, 1'b1, 3'd1));
    for (int k = 0; k < 4; k++) vq.push_back(mk(8'h0c, 1'b0, 8'h00, 1'b1, 3'd1));
    vq.push_back(mk(8'h0c, 1'b1, 8'h04, 1'b1, 3'd2));
    // Lane 3 requests during a stall then withdraws; ptr must still be 3
    vq.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd2));
    vq.push_back(mk(8'h08, 1'b0, 8'h00, 1'b1, 3'd2));
    vq.push_back(mk(8'h00, 1'b0, 8'h00, 1'b1, 3'd2));
    vq.push_back(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd2));
    vq.push_back(mk(8'h09, 1'b1, 8'h08, 1'b1, 3'd3));

    foreach (vq[i]) step(vq[i].val, vq[i].srdy, vq[i].erdy, vq[i].esv, vq[i].egid,
                         $sformatf("vec%0d", i));

    // Reset while the buffer holds a word
    reset        = 1'b1;
    bus.recv_val = 8'hff;
    bus.send_rdy = 1'b0;
    #4;
    chk("midrst.recv_rdy", 32'(bus.recv_rdy), 32'h0);
    @(posedge clk);
    #1;
    chk("midrst.send_val", 32'(bus.send_val), 32'h0);
    chk("midrst.grant_id", 32'(bus.grant_id), 32'h0);
    chk("midrst.send_msg", bus.send_msg, 32'h0);
    reset = 1'b0;
    step(8'hff, 1'b1, 8'h01, 1'b1, 3'd0, "postrst");

`ifdef RR_ARBITER8_LOCK_EN
    // Lane 1 sends a 3-word packet while lane 4 waits; lane 1 idles mid-packet
    bus.recv_last = 8'h00;
    step(8'h12, 1'b1, 8'h02, 1'b1, 3'd1, "lock.w1");
    step(8'h10, 1'b1, 8'h00, 1'b0, 3'd1, "lock.idle");
    step(8'h12, 1'b1, 8'h02, 1'b1, 3'd1, "lock.w2");
    bus.recv_last = 8'h02;
    step(8'h12, 1'b1, 8'h02, 1'b1, 3'd1, "lock.w3");
    bus.recv_last = 8'hff;
    step(8'h12, 1'b1, 8'h10, 1'b1, 3'd4, "lock.after");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
